// File: rtl/dac_shift_controller.sv
// rtl/dac_shift_controller.sv - automatic left-shift control for the DAC output corrector
module dac_shift_controller #(
  parameter int WINDOW_LEN   = 4096,
  parameter int HEADROOM     = 1,
  parameter int MAX_SHIFT    = 14,
  parameter int HOLD_WINDOWS = 4,
  parameter int INIT_SHIFT   = 0
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [27:0] DATA_IN,
  input  logic        auto_en,
  input  logic [7:0]  manual_distance,
  output logic [7:0]  distance,
  output logic        update_strobe,
  output logic        clip_flag,
  output logic [4:0]  peak_rsb
);

  localparam int CW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int HW = $clog2(HOLD_WINDOWS + 1);

  typedef enum logic [1:0] {ST_MANUAL, ST_MEASURE, ST_EVAL} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    win_peak;
  logic [HW-1:0] hold;

  logic [26:0]   mag;
  logic [4:0]    rsb;
  logic [4:0]    peak_min;
  logic          fast_attack;
  logic [7:0]    desired;

  // Magnitude with -2^27 saturated, then leading-zero count of the low 27 bits.
  always_comb begin
    mag = DATA_IN[27] ? (~DATA_IN[26:0] + 27'd1) : DATA_IN[26:0];
    if (DATA_IN[27] && (DATA_IN[26:0] == 27'd0)) mag = '1;
    rsb = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (mag[i]) rsb = 5'(26 - i);
    end
  end

  assign peak_min    = (rsb < win_peak) ? rsb : win_peak;
  assign fast_attack = sample_valid && ({3'b000, rsb} < distance);

  always_comb begin
    int d;
    d = int'(win_peak) - HEADROOM;
    if (d < 0) d = 0;
    if (d > MAX_SHIFT) d = MAX_SHIFT;
    desired = 8'(d);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_MANUAL;
      cnt           <= '0;
      win_peak      <= 5'd27;
      hold          <= '0;
      distance      <= 8'(INIT_SHIFT);
      update_strobe <= 1'b0;
      clip_flag     <= 1'b0;
      peak_rsb      <= 5'd27;
    end else begin
      update_strobe <= 1'b0;
      clip_flag     <= 1'b0;
      case (state)
        ST_MANUAL: begin
          distance      <= manual_distance;
          update_strobe <= (manual_distance != distance);
          cnt           <= '0;
          win_peak      <= 5'd27;
          hold          <= '0;
          if (auto_en) state <= ST_MEASURE;
        end
        ST_MEASURE, ST_EVAL: begin
          if (!auto_en) begin
            state    <= ST_MANUAL;
            cnt      <= '0;
            win_peak <= 5'd27;
            hold     <= '0;
          end else begin
            if (state == ST_EVAL) begin
              peak_rsb <= win_peak;
              if (desired < distance) begin
                distance      <= desired;
                hold          <= '0;
                update_strobe <= 1'b1;
              end else if (desired > distance) begin
                if (hold == HW'(HOLD_WINDOWS - 1)) begin
                  distance      <= distance + 8'd1;
                  hold          <= '0;
                  update_strobe <= 1'b1;
                end else begin
                  hold <= hold + 1'b1;
                end
              end else begin
                hold <= '0;
              end
              // A sample arriving during evaluation opens the next window.
              cnt      <= sample_valid ? CW'(1) : '0;
              win_peak <= sample_valid ? rsb : 5'd27;
              state    <= ST_MEASURE;
            end else if (sample_valid) begin
              cnt      <= cnt + 1'b1;
              win_peak <= peak_min;
              if (cnt == CW'(WINDOW_LEN - 1)) state <= ST_EVAL;
            end
            // Placed last so it overrides any evaluation result in the same cycle.
            if (fast_attack) begin
              distance      <= {3'b000, rsb};
              clip_flag     <= 1'b1;
              update_strobe <= 1'b1;
              hold          <= '0;
            end
          end
        end
        default: state <= ST_MANUAL;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_shift_controller.sv
// tb/tb_dac_shift_controller.sv - directed self-checking bench for dac_shift_controller
module tb_dac_shift_controller;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [27:0] DATA_IN;
  logic        auto_en;
  logic [7:0]  manual_distance;
  logic [7:0]  distance;
  logic        update_strobe;
  logic        clip_flag;
  logic [4:0]  peak_rsb;

  int errors = 0;
  int checks = 0;

  localparam logic [27:0] S_1000  = 28'd1000;      // rsb 17
  localparam logic [27:0] S_P2_20 = 28'h0100000;   // +2^20, rsb 6
  localparam logic [27:0] S_N2_24 = 28'hF000000;   // -2^24, rsb 2
  localparam logic [27:0] S_N2_27 = 28'h8000000;   // -2^27, rsb 0

  dac_shift_controller #(
    .WINDOW_LEN(16), .HEADROOM(1), .MAX_SHIFT(14), .HOLD_WINDOWS(4), .INIT_SHIFT(0)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n), .sample_valid(sample_valid), .DATA_IN(DATA_IN),
    .auto_en(auto_en), .manual_distance(manual_distance), .distance(distance),
    .update_strobe(update_strobe), .clip_flag(clip_flag), .peak_rsb(peak_rsb)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [27:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      DATA_IN = v;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sample_valid = 1'b0; DATA_IN = '0; auto_en = 1'b0; manual_distance = 8'd0;
    tick(); tick();
    checks++; if (distance !== 8'd0) begin errors++; $display("FAIL reset_distance got=%0d exp=0", distance); end
    checks++; if (peak_rsb !== 5'd27) begin errors++; $display("FAIL reset_peak got=%0d exp=27", peak_rsb); end
    checks++; if (update_strobe !== 1'b0 || clip_flag !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", update_strobe, clip_flag); end
    reset_n = 1'b1;
  endtask

  task automatic test_manual();
    tick();
    manual_distance = 8'd3; tick();
    manual_distance = 8'd7; tick();
    checks++; if (distance !== 8'd7) begin errors++; $display("FAIL manual_value got=%0d exp=7", distance); end
    checks++; if (update_strobe !== 1'b1) begin errors++; $display("FAIL manual_strobe got=%b exp=1", update_strobe); end
    tick();
    checks++; if (update_strobe !== 1'b0) begin errors++; $display("FAIL manual_single_pulse got=%b exp=0", update_strobe); end
    tick();
    checks++; if (update_strobe !== 1'b0 || distance !== 8'd7) begin errors++; $display("FAIL manual_repeat got=%b/%0d exp=0/7", update_strobe, distance); end
  endtask

  task automatic test_release();
    int k;
    int exp_d;
    logic exp_s;
    manual_distance = 8'd0; tick();
    auto_en = 1'b1; tick();
    for (int t = 1; t <= 960; t++) begin
      sample_valid = 1'b1; DATA_IN = S_1000;
      tick();
      k = (t - 1) / 16;
      exp_d = (k / 4 > 14) ? 14 : k / 4;
      exp_s = ((t - 1) % 16 == 0) && (k > 0) && (k % 4 == 0);
      checks++; if (distance !== 8'(exp_d)) begin errors++; $display("FAIL release_distance t=%0d got=%0d exp=%0d", t, distance, exp_d); end
      checks++; if (update_strobe !== exp_s) begin errors++; $display("FAIL release_strobe t=%0d got=%b exp=%b", t, update_strobe, exp_s); end
    end
    sample_valid = 1'b0; tick();
    checks++; if (distance !== 8'd14) begin errors++; $display("FAIL release_clamp got=%0d exp=14", distance); end
    checks++; if (peak_rsb !== 5'd17) begin errors++; $display("FAIL release_peak got=%0d exp=17", peak_rsb); end
  endtask

  task automatic test_fast_attack();
    send(S_P2_20, 1);
    checks++; if (distance !== 8'd6) begin errors++; $display("FAIL fa_distance got=%0d exp=6", distance); end
    checks++; if (clip_flag !== 1'b1 || update_strobe !== 1'b1) begin errors++; $display("FAIL fa_pulses got=%b%b exp=11", clip_flag, update_strobe); end
    send(S_1000, 1);
    checks++; if (clip_flag !== 1'b0 || update_strobe !== 1'b0) begin errors++; $display("FAIL fa_pulse_width got=%b%b exp=00", clip_flag, update_strobe); end
    send(S_1000, 14);
    tick();
    checks++; if (distance !== 8'd5 || update_strobe !== 1'b1) begin errors++; $display("FAIL fa_window_eval got=%0d/%b exp=5/1", distance, update_strobe); end
    checks++; if (peak_rsb !== 5'd6) begin errors++; $display("FAIL fa_peak got=%0d exp=6", peak_rsb); end
  endtask

  task automatic test_window_decrease();
    auto_en = 1'b0; manual_distance = 8'd10; tick(); tick();
    auto_en = 1'b1; tick();
    checks++; if (distance !== 8'd10) begin errors++; $display("FAIL wd_setup got=%0d exp=10", distance); end
    send(S_N2_24, 1);
    checks++; if (distance !== 8'd2 || clip_flag !== 1'b1) begin errors++; $display("FAIL wd_fast got=%0d/%b exp=2/1", distance, clip_flag); end
    send(S_1000, 15);
    tick();
    checks++; if (distance !== 8'd1 || peak_rsb !== 5'd2) begin errors++; $display("FAIL wd_eval got=%0d/%0d exp=1/2", distance, peak_rsb); end
    send(S_N2_27, 1);
    checks++; if (distance !== 8'd0 || clip_flag !== 1'b1) begin errors++; $display("FAIL wd_full_scale got=%0d/%b exp=0/1", distance, clip_flag); end
    send(S_1000, 15);
    tick();
    checks++; if (distance !== 8'd0 || update_strobe !== 1'b0 || peak_rsb !== 5'd0) begin errors++; $display("FAIL wd_floor got=%0d/%b/%0d exp=0/0/0", distance, update_strobe, peak_rsb); end
  endtask

  task automatic test_back_to_back();
    auto_en = 1'b0; manual_distance = 8'd12; tick(); tick();
    auto_en = 1'b1; tick();
    send(S_1000, 16);
    send(S_P2_20, 1);
    checks++; if (distance !== 8'd6 || clip_flag !== 1'b1) begin errors++; $display("FAIL b2b_fast_wins got=%0d/%b exp=6/1", distance, clip_flag); end
    checks++; if (peak_rsb !== 5'd17) begin errors++; $display("FAIL b2b_peak got=%0d exp=17", peak_rsb); end
    send(S_1000, 15);
    tick();
    checks++; if (distance !== 8'd5 || peak_rsb !== 5'd6) begin errors++; $display("FAIL b2b_count got=%0d/%0d exp=5/6", distance, peak_rsb); end
  endtask

  task automatic test_auto_drop();
    send(S_1000, 3);
    auto_en = 1'b0; manual_distance = 8'd9;
    tick(); tick();
    checks++; if (distance !== 8'd9) begin errors++; $display("FAIL drop_manual got=%0d exp=9", distance); end
    checks++; if (peak_rsb !== 5'd6) begin errors++; $display("FAIL drop_peak_kept got=%0d exp=6", peak_rsb); end
  endtask

  task automatic test_reset_midwindow();
    logic bad;
    auto_en = 1'b1; tick();
    send(S_1000, 5);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (distance !== 8'd0) begin errors++; $display("FAIL async_distance got=%0d exp=0", distance); end
    checks++; if (peak_rsb !== 5'd27 || update_strobe !== 1'b0 || clip_flag !== 1'b0) begin errors++; $display("FAIL async_state got=%0d/%b%b exp=27/00", peak_rsb, update_strobe, clip_flag); end
    manual_distance = 8'd0; tick();
    reset_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      send(S_1000, 1);
      if (update_strobe !== 1'b0 || distance !== 8'd0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL post_reset_quiet got=update exp=none"); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_release();
    test_fast_attack();
    test_window_decrease();
    test_back_to_back();
    test_auto_drop();
    test_reset_midwindow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
